// File: rtl/request_unit.sv
// request_unit: sequences fetch and data requests from the decoded control
// levels, produces the PC-advance strobe and owns the LL/SC link register.
module request_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              LinkLoad,
    input  logic              StoreCond,
    input  logic              halt,
    input  logic [ADDR_W-1:0] daddr,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              pc_en,
    output logic              sc_result,
    output logic              link_valid,
    output logic              halted
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    // Access kind; bit 1 set means the access writes memory.
    localparam logic [1:0] K_LW = 2'd0;
    localparam logic [1:0] K_LL = 2'd1;
    localparam logic [1:0] K_SW = 2'd2;
    localparam logic [1:0] K_SC = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        r_kind;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_link_addr;
    logic              r_link_valid;
    logic              r_sc_result;
    logic              r_halted;

    logic [1:0]        w_next_state;
    logic [1:0]        w_kind;
    logic              w_go_data;
    logic              w_pc_fetch;
    logic              w_sc_eval;
    logic              w_sc_ok;
    logic              w_data_done;
    logic              w_link_set;
    logic              w_link_clr;

    assign w_sc_ok     = r_link_valid && (r_link_addr == daddr);
    assign w_data_done = (r_state == S_DATA) && dhit;

    // Next-state and decode: priority halt > LL > SC > LW > SW on the ihit cycle.
    always_comb begin
        w_next_state = r_state;
        w_kind       = K_LW;
        w_go_data    = 1'b0;
        w_pc_fetch   = 1'b0;
        w_sc_eval    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (ihit) begin
                    if (halt) begin
                        w_next_state = S_HALTED;
                    end else if (LinkLoad) begin
                        w_go_data    = 1'b1;
                        w_kind       = K_LL;
                        w_next_state = S_DATA;
                    end else if (StoreCond) begin
                        w_sc_eval = 1'b1;
                        if (w_sc_ok) begin
                            w_go_data    = 1'b1;
                            w_kind       = K_SC;
                            w_next_state = S_DATA;
                        end else begin
                            w_pc_fetch = 1'b1;
                        end
                    end else if (MemRead) begin
                        w_go_data    = 1'b1;
                        w_kind       = K_LW;
                        w_next_state = S_DATA;
                    end else if (MemWrite) begin
                        w_go_data    = 1'b1;
                        w_kind       = K_SW;
                        w_next_state = S_DATA;
                    end else begin
                        w_pc_fetch = 1'b1;
                    end
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DATA: begin
                if (dhit) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_DATA;
                end
            end
            S_HALTED: begin
                w_next_state = S_HALTED;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Link update terms: a completing LL sets; stores to the link, any SC and
    // matching snoops clear. A failed SC completes on its ihit cycle.
    always_comb begin
        w_link_set = w_data_done && (r_kind == K_LL);
        w_link_clr = 1'b0;
        if (snoop_valid && (snoop_addr == r_link_addr)) begin
            w_link_clr = 1'b1;
        end else if (w_sc_eval && !w_sc_ok) begin
            w_link_clr = 1'b1;
        end else if (w_data_done && (r_kind == K_SC)) begin
            w_link_clr = 1'b1;
        end else if (w_data_done && (r_kind == K_SW) && (r_addr == r_link_addr)) begin
            w_link_clr = 1'b1;
        end else begin
            w_link_clr = 1'b0;
        end
    end

    // Cache enables and commit strobe, combinational from state and hits.
    always_comb begin
        iREN  = (r_state == S_FETCH);
        dREN  = (r_state == S_DATA) && !r_kind[1];
        dWEN  = (r_state == S_DATA) &&  r_kind[1];
        pc_en = w_pc_fetch || w_data_done;
    end

    assign sc_result  = r_sc_result;
    assign link_valid = r_link_valid;
    assign halted     = r_halted;

    // State, latched access, link register and sticky flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_kind       <= K_LW;
            r_addr       <= {ADDR_W{1'b0}};
            r_link_addr  <= {ADDR_W{1'b0}};
            r_link_valid <= 1'b0;
            r_sc_result  <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_go_data) begin
                r_kind <= w_kind;
                r_addr <= daddr;
            end
            if (w_sc_eval) begin
                r_sc_result <= w_sc_ok;
            end
            // A same-cycle snoop is ordered before the completing LL.
            if (w_link_set) begin
                r_link_valid <= 1'b1;
                r_link_addr  <= r_addr;
            end else if (w_link_clr) begin
                r_link_valid <= 1'b0;
            end
            if (w_next_state == S_HALTED) begin
                r_halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit: each issued instruction pushes its
// expected commit profile; a negedge monitor checks it on every pc_en.
module tb_request_unit;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, MemRead, MemWrite, LinkLoad, StoreCond, halt;
    logic [31:0] daddr, snoop_addr;
    logic        snoop_valid;
    logic        iREN, dREN, dWEN, pc_en, sc_result, link_valid, halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        int    ren;
        int    wen;
        logic  iren;
    } exp_t;

    exp_t exp_q[$];
    int   ren_cnt = 0;
    int   wen_cnt = 0;

    // op bit order: {halt, LinkLoad, StoreCond, MemRead, MemWrite}
    localparam logic [4:0] OP_ALU = 5'b00000;
    localparam logic [4:0] OP_MW  = 5'b00001;
    localparam logic [4:0] OP_MR  = 5'b00010;
    localparam logic [4:0] OP_SC  = 5'b00100;
    localparam logic [4:0] OP_LL  = 5'b01000;
    localparam logic [4:0] OP_HLT = 5'b10010;

    request_unit #(.ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .MemRead(MemRead), .MemWrite(MemWrite), .LinkLoad(LinkLoad),
        .StoreCond(StoreCond), .halt(halt), .daddr(daddr),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .pc_en(pc_en),
        .sc_result(sc_result), .link_valid(link_valid), .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Monitor: count data-enable cycles, check each commit against the queue.
    always @(negedge CLK) begin
        exp_t e;
        if (dREN) ren_cnt++;
        if (dWEN) wen_cnt++;
        if (dREN && dWEN) begin
            checks++; errors++;
            $display("FAIL both_enables: dREN=1 dWEN=1 required never both");
        end
        if (pc_en && !RST) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pc_en: got pc_en=1 required no commit");
            end else begin
                e = exp_q.pop_front();
                if (ren_cnt != e.ren || wen_cnt != e.wen || iREN != e.iren) begin
                    errors++;
                    $display("FAIL commit_%s: got ren=%0d wen=%0d iREN=%0b required ren=%0d wen=%0d iREN=%0b",
                             e.name, ren_cnt, wen_cnt, iREN, e.ren, e.wen, e.iren);
                end
            end
            ren_cnt = 0;
            wen_cnt = 0;
        end
        if (RST) begin
            ren_cnt = 0;
            wen_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!iREN && n < 20) begin
            tick();
            n++;
        end
        if (!iREN) begin
            checks++; errors++;
            $display("FAIL wait_fetch: iREN=0 after 20 cycles required 1");
        end
    endtask

    task automatic set_ctl(input logic [4:0] op);
        {halt, LinkLoad, StoreCond, MemRead, MemWrite} = op;
    endtask

    // Issue one instruction; n = DATA cycles with dhit on the last (0 = none).
    task automatic issue(input string name, input logic [4:0] op, input logic [31:0] addr,
                         input int n, input int exp_ren, input int exp_wen);
        exp_t e;
        wait_fetch();
        e.name = name; e.ren = exp_ren; e.wen = exp_wen;
        e.iren = (exp_ren == 0 && exp_wen == 0);
        exp_q.push_back(e);
        set_ctl(op);
        daddr = addr;
        ihit  = 1'b1;
        tick();
        ihit  = 1'b0;
        // Scramble controls and address: the unit must use its latched copies.
        set_ctl(OP_LL | OP_MW);
        daddr = 32'hDEAD_BEEF;
        if (n > 0) begin
            for (int i = 0; i < n - 1; i++) tick();
            dhit = 1'b1;
            tick();
            dhit = 1'b0;
        end
        set_ctl(OP_ALU);
    endtask

    task automatic snoop(input logic [31:0] addr);
        snoop_valid = 1'b1;
        snoop_addr  = addr;
        tick();
        snoop_valid = 1'b0;
        snoop_addr  = 32'h0;
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; dhit = 1'b0; daddr = 32'h0;
        snoop_valid = 1'b0; snoop_addr = 32'h0;
        set_ctl(OP_ALU);
        tick();
        tick();
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_dREN_dWEN", {30'd0, dREN, dWEN}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("rst_flags", {29'd0, sc_result, link_valid, halted}, 32'd0);
        RST = 1'b0;
        chk("idle_iREN", {31'd0, iREN}, 32'd0);
        tick();
        chk("fetch_iREN", {31'd0, iREN}, 32'd1);

        // ALU op: ihit in cycle 2 after release, commit on the ihit cycle.
        issue("alu", OP_ALU, 32'h0, 0, 0, 0);
        // dhit outside DATA must be ignored (monitor flags any pc_en).
        dhit = 1'b1; tick(); dhit = 1'b0;

        // LW 0x100 with dhit in the third DATA cycle.
        issue("lw", OP_MR, 32'h100, 3, 3, 0);
        chk("lw_link", {31'd0, link_valid}, 32'd0);
        // MemRead and MemWrite together decode as a read.
        issue("rd_prio", OP_MR | OP_MW, 32'h104, 1, 1, 0);

        // LL 0x200 then successful SC 0x200.
        issue("ll1", OP_LL, 32'h200, 1, 1, 0);
        chk("ll1_link", {31'd0, link_valid}, 32'd1);
        issue("sc_ok", OP_SC, 32'h200, 2, 0, 2);
        chk("sc_ok_result", {31'd0, sc_result}, 32'd1);
        chk("sc_ok_link", {31'd0, link_valid}, 32'd0);

        // LL, non-matching snoop, matching snoop, then failing SC.
        issue("ll2", OP_LL, 32'h200, 1, 1, 0);
        snoop(32'h204);
        chk("snoop_other_link", {31'd0, link_valid}, 32'd1);
        snoop(32'h200);
        chk("snoop_hit_link", {31'd0, link_valid}, 32'd0);
        issue("sc_fail", OP_SC, 32'h200, 0, 0, 0);
        chk("sc_fail_result", {31'd0, sc_result}, 32'd0);

        // LL, SW to a neighbour keeps the link, SW to the link clears it.
        issue("ll3", OP_LL, 32'h200, 2, 2, 0);
        issue("sw_204", OP_MW, 32'h204, 1, 0, 1);
        chk("sw_204_link", {31'd0, link_valid}, 32'd1);
        issue("sw_200", OP_MW, 32'h200, 2, 0, 2);
        chk("sw_200_link", {31'd0, link_valid}, 32'd0);

        // Reset in the middle of DATA abandons the access and the link.
        issue("ll4", OP_LL, 32'h300, 1, 1, 0);
        wait_fetch();
        set_ctl(OP_MR); daddr = 32'h400; ihit = 1'b1;
        tick();
        ihit = 1'b0; set_ctl(OP_ALU);
        chk("mid_data_dREN", {31'd0, dREN}, 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_dREN", {31'd0, dREN}, 32'd0);
        chk("mid_rst_link", {31'd0, link_valid}, 32'd0);
        issue("alu2", OP_ALU, 32'h0, 0, 0, 0);

        // HALT wins over MemRead; then terminal until reset.
        wait_fetch();
        set_ctl(OP_HLT); ihit = 1'b1;
        tick();
        set_ctl(OP_ALU);
        chk("halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            ihit = 1'b1; dhit = 1'b1;
            tick();
            chk("halt_enables", {28'd0, iREN, dREN, dWEN, pc_en}, 32'd0);
        end
        ihit = 1'b0; dhit = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("halt_rst", {31'd0, halted}, 32'd0);
        tick();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/request_unit.md
# request_unit

Sequencer between the single-cycle datapath's decoded control signals and the instruction/data cache ports. It turns the level control outputs (MemRead, MemWrite, LL, SC, halt) into a fetch/data request handshake and generates the PC-advance strobe. It also owns the LL/SC link register, including invalidation by local stores and coherence snoops. It sits beside the control unit in the datapath top level and drives iREN/dREN/dWEN toward the cache interface.

## Interface
- ADDR_W, 32, width of data addresses and link register
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- ihit  in  1  instruction port hit; instruction and decoded controls valid this cycle
- dhit  in  1  data port hit; data request completes this cycle
- MemRead  in  1  decoded load (LW)
- MemWrite  in  1  decoded store (SW)
- LinkLoad  in  1  decoded LL
- StoreCond  in  1  decoded SC
- halt  in  1  decoded HALT
- daddr  in  ADDR_W  ALU effective address, valid with ihit and held through DATA
- snoop_valid  in  1  coherence invalidation strobe
- snoop_addr  in  ADDR_W  invalidated address
- iREN  out  1  instruction read enable
- dREN  out  1  data read enable
- dWEN  out  1  data write enable
- pc_en  out  1  one-cycle strobe: commit current instruction, advance PC, enable RegWrite
- sc_result  out  1  SC outcome written to rt: 1 success, 0 fail
- link_valid  out  1  link register valid
- halted  out  1  sticky halt indication

## Operation
- States: IDLE, FETCH, DATA, HALTED. RST forces IDLE; IDLE -> FETCH unconditionally next cycle.
- IDLE: all outputs 0.
- FETCH: iREN=1. Without ihit, hold FETCH with no other output.
- On ihit, decode priority is halt > LinkLoad > StoreCond > MemRead > MemWrite.
  - halt: go to HALTED; pc_en=0.
  - LinkLoad or MemRead: go to DATA as a read.
  - MemWrite: go to DATA as a write.
  - StoreCond with link_valid=1 and link_addr==daddr: go to DATA as a write; set sc_result=1 next edge.
  - StoreCond otherwise: no memory access; pc_en=1 this cycle; sc_result=0 next edge; stay in FETCH.
  - Anything else: pc_en=1 this cycle; stay in FETCH.
- DATA: iREN=0; dREN=1 for a read, dWEN=1 for a write; never both. Operation kind and address are latched at FETCH exit. Hold until dhit; on dhit, pc_en=1 and go to FETCH.
- Link register:
  - LL completing (dhit): link_valid<=1, link_addr<=latched address.
  - SW completing with address == link_addr: link_valid<=0.
  - Any SC completing, successful or failed: link_valid<=0.
  - snoop_valid with snoop_addr==link_addr: link_valid<=0, in any state.
  - Same-cycle LL set and snoop clear: set wins, since the snoop precedes the load.
- HALTED: all enables 0, pc_en=0, halted=1. Terminal until RST.
- Address compare is full ADDR_W equality; no word masking.

## Timing
- Reset values, cycle after RST sampled high: state IDLE; iREN, dREN, dWEN, pc_en, sc_result, link_valid, halted all 0; link_addr 0.
- RST mid-DATA: enables drop at the next edge; the pending access is abandoned and the link is cleared.
- Non-memory instruction: pc_en asserts in the same cycle as ihit; minimum 1 cycle per instruction.
- Memory instruction: 1 FETCH cycle + N DATA cycles, where dhit arrives in cycle N (N>=1); pc_en coincides with dhit.
- Outputs iREN, dREN, dWEN, pc_en are combinational from state and hit inputs. sc_result, link_valid, halted are registered.
- dhit while not in DATA: ignored. ihit while not in FETCH: ignored.
- Controls are sampled only on the ihit cycle; changes during DATA have no effect.

## Test plan
- Reset then ALU op: RST 2 cycles, ihit in cycle 2 after release -> iREN rises 1 cycle after RST low; pc_en=1 on the ihit cycle; dREN=dWEN=0 throughout.
- LW with dhit after 3 cycles, daddr=0x100 -> dREN=1 for exactly 3 cycles; pc_en pulses only on the dhit cycle; iREN=0 during DATA.
- LL 0x200 then SC 0x200 -> link_valid=1 after the LL dhit; SC enters DATA with dWEN; sc_result=1; link_valid=0 after the SC dhit.
- LL 0x200, snoop 0x200, then SC 0x200 -> link_valid cleared the cycle after the snoop; SC gives no dWEN, pc_en on the ihit cycle, sc_result=0.
- LL 0x200, SW 0x204, SW 0x200 -> link survives the 0x204 store; cleared after the 0x200 store dhit.
- HALT on ihit -> halted=1 next cycle; no further iREN/pc_en regardless of ihit/dhit until RST.
